// File: rtl/regdst_pkg.sv
// Shared RegDst select codes and default special-register indices.
// No logic; constants only.
// Imported by the tracker top and its pending-destination FIFO.
package regdst_pkg;

    localparam logic [2:0] RD_RT = 3'b000;
    localparam logic [2:0] RD_RD = 3'b001;
    localparam logic [2:0] RD_SP = 3'b010;
    localparam logic [2:0] RD_RA = 3'b011;
    localparam logic [2:0] RD_D4 = 3'b100;
    localparam logic [2:0] RD_D5 = 3'b101;

    localparam int SP_IDX_DEF = 29;
    localparam int RA_IDX_DEF = 31;

endpackage

// File: rtl/regdst_fifo.sv
// Pending-destination queue: DEPTH x W synchronous FIFO exposing every slot and a valid mask.
// Latency: push/pop take effect at the next clock; head_dat is combinational from the read pointer.
// Backpressure: none internally; the caller must not push when full unless it pops in the same cycle.
// Ports: clk/reset (sync, active-high), push/push_dat, pop, head_dat, ent_dat/ent_vld (all slots), count.
module regdst_fifo
    import regdst_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int W     = 5,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [W-1:0]            push_dat,
    input  logic                    pop,
    output logic [W-1:0]            head_dat,
    output logic [DEPTH-1:0][W-1:0] ent_dat,
    output logic [DEPTH-1:0]        ent_vld,
    output logic [CNT_W-1:0]        count
);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // A slot is live when its distance from the read pointer is below count;
    // count alone tells full from empty since the pointers coincide in both.
    always_comb begin
        ent_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_vld[i] = (CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr_q)) < count_q);
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign ent_dat  = mem_q;
    assign count    = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: slots are only read while marked valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/regdst_wb_tracker.sv
// Decodes RegDst at issue, queues destination indices, retires them in order to the RF write port.
// Latency: wr_en/wr_idx one cycle after commit; busy/count one cycle after push/pop.
// Backpressure: issue_ready low when the queue is full (REGDST_FULL_BYPASS_EN lets a same-cycle commit free a slot).
// Ports: clk, reset (sync, active-high), data0/1/4/5 + RegDst (decode), issue_valid/issue_ready,
//        commit_valid, wr_en/wr_idx (registered), busy (per register), count, sel_err/underflow (sticky).
// Optional macro: REGDST_FULL_BYPASS_EN.
module regdst_wb_tracker
    import regdst_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int IDX_W  = 5,
    parameter  int DEPTH  = 4,
    parameter  int SP_IDX = SP_IDX_DEF,
    parameter  int RA_IDX = RA_IDX_DEF,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     data0,
    input  logic [DATA_W-1:0]     data1,
    input  logic [DATA_W-1:0]     data4,
    input  logic [DATA_W-1:0]     data5,
    input  logic [2:0]            RegDst,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic                  commit_valid,
    output logic                  wr_en,
    output logic [IDX_W-1:0]      wr_idx,
    output logic [2**IDX_W-1:0]   busy,
    output logic [CNT_W-1:0]      count,
    output logic                  sel_err,
    output logic                  underflow
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [IDX_W-1:0]            dec_idx;
    logic                        dec_legal;
    logic                        issue_fire;
    logic                        push;
    logic                        pop;
    logic                        q_empty;
    logic [IDX_W-1:0]            head_dat;
    logic [DEPTH-1:0][IDX_W-1:0] ent_dat;
    logic [DEPTH-1:0]            ent_vld;

    logic                        wr_en_q, wr_en_d;
    logic [IDX_W-1:0]            wr_idx_q, wr_idx_d;
    logic                        sel_err_q, sel_err_d;
    logic                        underflow_q, underflow_d;

    // Only the low IDX_W bits of each candidate name a register.
    logic unused_data_hi;
    assign unused_data_hi = ^{data0[DATA_W-1:IDX_W], data1[DATA_W-1:IDX_W],
                              data4[DATA_W-1:IDX_W], data5[DATA_W-1:IDX_W]};

    always_comb begin
        dec_idx   = '0;
        dec_legal = 1'b1;
        case (RegDst)
            RD_RT:   dec_idx = data0[IDX_W-1:0];
            RD_RD:   dec_idx = data1[IDX_W-1:0];
            RD_SP:   dec_idx = IDX_W'(SP_IDX);
            RD_RA:   dec_idx = IDX_W'(RA_IDX);
            RD_D4:   dec_idx = data4[IDX_W-1:0];
            RD_D5:   dec_idx = data5[IDX_W-1:0];
            default: dec_legal = 1'b0;
        endcase
    end

    assign q_empty = (count == '0);

`ifdef REGDST_FULL_BYPASS_EN
    // The slot freed by a same-cycle commit is reused immediately.
    assign issue_ready = (count != FULL_CNT) | (commit_valid & ~q_empty);
`else
    assign issue_ready = (count != FULL_CNT);
`endif

    assign issue_fire = issue_valid & issue_ready;
    assign push       = issue_fire & dec_legal;
    // Commit only sees entries already queued, so an issue into an empty
    // queue never satisfies a same-cycle commit.
    assign pop        = commit_valid & ~q_empty;

    regdst_fifo #(
        .DEPTH (DEPTH),
        .W     (IDX_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (dec_idx),
        .pop      (pop),
        .head_dat (head_dat),
        .ent_dat  (ent_dat),
        .ent_vld  (ent_vld),
        .count    (count)
    );

    // r0 is hardwired, so a pending write to it never blocks anyone.
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_dat[i] != '0)) begin
                busy[ent_dat[i]] = 1'b1;
            end
        end
    end

    always_comb begin
        wr_en_d     = pop & (head_dat != '0);
        wr_idx_d    = pop ? head_dat : wr_idx_q;
        sel_err_d   = sel_err_q | (issue_fire & ~dec_legal);
        underflow_d = underflow_q | (commit_valid & q_empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q     <= 1'b0;
            wr_idx_q    <= '0;
            sel_err_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_en_q     <= wr_en_d;
            wr_idx_q    <= wr_idx_d;
            sel_err_q   <= sel_err_d;
            underflow_q <= underflow_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_idx    = wr_idx_q;
    assign sel_err   = sel_err_q;
    assign underflow = underflow_q;

endmodule
